// File: rtl/pipe_bus_ctrl.sv
// Arbitrates the single external memory bus between instruction fetch (IF) and
// data access (MEM), and produces the 6-bit pipeline stall vector.
// Stall vector bits: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB, 1 = stop.
module pipe_bus_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        flush,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        bus_err,
    output logic [5:0]  stall
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned VW = 6;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [VW-1:0] STALL_MEM  = 6'b011111;
    localparam logic [VW-1:0] STALL_EX   = 6'b001111;
    localparam logic [VW-1:0] STALL_ID   = 6'b000111;
    localparam logic [VW-1:0] STALL_IF   = 6'b000011;
    localparam logic [VW-1:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_MEM_BUSY = 2'd2,
        ST_IF_DRAIN = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [SW-1:0]   bus_sel_q, bus_sel_d;
    logic [DW-1:0]   bus_addr_q, bus_addr_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;

    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   mem_rdata_q, mem_rdata_d;
    logic            if_valid_q, if_valid_d;
    logic            mem_valid_q, mem_valid_d;
    logic            bus_err_q, bus_err_d;

    logic            in_xfer_c;
    logic            timeout_c;
    logic            mem_wait_c;
    logic            if_wait_c;
    logic [VW-1:0]   stall_c;

    // Transfer-in-flight and timeout-expiry qualifiers shared by the next-state logic.
    always_comb begin
        in_xfer_c = (state_q != ST_IDLE);
        timeout_c = in_xfer_c && !bus_ack && (cnt_q == TO_LAST);
    end

    // State, timeout counter and registered bus/response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Next-state: grant from IDLE (MEM first), finish on ack, abort on timeout,
    // and divert a flushed fetch into IF_DRAIN so its late data is thrown away.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    state_d     = ST_MEM_BUSY;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_sel_d   = mem_sel;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                end else if (if_req && !flush) begin
                    state_d     = ST_IF_BUSY;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = 4'hF;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                end
            end

            ST_IF_BUSY, ST_MEM_BUSY, ST_IF_DRAIN: begin
                if (bus_ack || timeout_c) begin
                    // Transfer ends either way; the bus returns to an idle pattern.
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = '0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    if (bus_ack) begin
                        if (state_q == ST_MEM_BUSY) begin
                            mem_rdata_d = bus_rdata;
                            mem_valid_d = 1'b1;
                        end else if ((state_q == ST_IF_BUSY) && !flush) begin
                            // A flush coinciding with the ack makes the word wrong-path.
                            if_rdata_d = bus_rdata;
                            if_valid_d = 1'b1;
                        end
                    end else begin
                        bus_err_d = 1'b1;
                    end
                end else if ((state_q == ST_IF_BUSY) && flush) begin
                    state_d = ST_IF_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outstanding-work qualifiers: a busy owner waits until its ack, otherwise the raw request.
    always_comb begin
        mem_wait_c = (state_q == ST_MEM_BUSY) ? !bus_ack : mem_req;
        if_wait_c  = ((state_q == ST_IF_BUSY) || (state_q == ST_IF_DRAIN)) ? !bus_ack : if_req;
    end

    // Prioritised stall vector; flush and reset force a free-running pipeline.
    always_comb begin
        stall_c = STALL_NONE;
        if (!rst || flush) begin
            stall_c = STALL_NONE;
        end else if (mem_wait_c) begin
            stall_c = STALL_MEM;
        end else if (stallreq_ex) begin
            stall_c = STALL_EX;
        end else if (stallreq_id) begin
            stall_c = STALL_ID;
        end else if (if_wait_c) begin
            stall_c = STALL_IF;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_valid = mem_valid_q;
    assign bus_err   = bus_err_q;
    assign stall     = stall_c;

endmodule

// File: tb/tb_pipe_bus_ctrl.sv
// Directed bench for pipe_bus_ctrl with a transaction-level reference model
// checked every cycle, plus literal expectations on the key scenarios.
module tb_pipe_bus_ctrl;

    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, stallreq_id, stallreq_ex, flush, bus_ack;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_sel;
    logic        bus_req, bus_we, if_valid, mem_valid, bus_err;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr, bus_wdata, if_rdata, mem_rdata;
    logic [5:0]  stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_bus_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .flush(flush),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .bus_err(bus_err), .stall(stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (0 none, 1 fetch, 2 data), whether the
    // fetch has been flushed, and how many cycles the transfer has waited.
    int          m_owner;
    bit          m_drop;
    int          m_age;
    logic        m_req, m_we, m_ifv, m_memv, m_err;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wdata, m_if_rd, m_mem_rd;

    task automatic model_release();
        m_owner = 0; m_drop = 0; m_age = 0;
        m_req = 1'b0; m_we = 1'b0; m_sel = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_release();
            m_if_rd = 32'h0; m_mem_rd = 32'h0;
            m_ifv = 1'b0; m_memv = 1'b0; m_err = 1'b0;
        end else begin
            m_ifv = 1'b0; m_memv = 1'b0; m_err = 1'b0;
            if (m_owner == 0) begin
                if (mem_req) begin
                    m_owner = 2; m_age = 0;
                    m_req = 1'b1; m_we = mem_we; m_sel = mem_sel;
                    m_addr = mem_addr; m_wdata = mem_wdata;
                end else if (if_req && !flush) begin
                    m_owner = 1; m_drop = 0; m_age = 0;
                    m_req = 1'b1; m_we = 1'b0; m_sel = 4'hF;
                    m_addr = if_addr; m_wdata = 32'h0;
                end
            end else if (bus_ack) begin
                if (m_owner == 2) begin
                    m_mem_rd = bus_rdata; m_memv = 1'b1;
                end else if (!m_drop && !flush) begin
                    m_if_rd = bus_rdata; m_ifv = 1'b1;
                end
                model_release();
            end else if (m_age == TIMEOUT - 1) begin
                m_err = 1'b1;
                model_release();
            end else if (m_owner == 1 && !m_drop && flush) begin
                m_drop = 1; m_age = 0;
            end else begin
                m_age++;
            end
        end
    end

    function automatic logic [5:0] model_stall();
        logic mem_pending, if_pending;
        mem_pending = (m_owner == 2) ? !bus_ack : mem_req;
        if_pending  = (m_owner == 1) ? !bus_ack : if_req;
        if (!rst || flush) return 6'b000000;
        if (mem_pending)   return 6'b011111;
        if (stallreq_ex)   return 6'b001111;
        if (stallreq_id)   return 6'b000111;
        if (if_pending)    return 6'b000011;
        return 6'b000000;
    endfunction

    // Every cycle out of reset, the DUT must agree with the model.
    always @(negedge clk) begin
        if (rst) begin
            check("m_stall",     32'(stall),     32'(model_stall()));
            check("m_bus_req",   32'(bus_req),   32'(m_req));
            check("m_bus_we",    32'(bus_we),    32'(m_we));
            check("m_bus_sel",   32'(bus_sel),   32'(m_sel));
            check("m_bus_addr",  bus_addr,       m_addr);
            check("m_bus_wdata", bus_wdata,      m_wdata);
            check("m_if_rdata",  if_rdata,       m_if_rd);
            check("m_if_valid",  32'(if_valid),  32'(m_ifv));
            check("m_mem_rdata", mem_rdata,      m_mem_rd);
            check("m_mem_valid", 32'(mem_valid), 32'(m_memv));
            check("m_bus_err",   32'(bus_err),   32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; stallreq_id = 1'b0;
        stallreq_ex = 1'b0; flush = 1'b0; bus_ack = 1'b0;
        if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; bus_rdata = 32'h0;
        mem_sel = 4'h0;
        tick(); tick();
        check("rst_bus_req", 32'(bus_req), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        rst = 1'b1;
        tick();

        // Fetch acked on the third busy cycle.
        if_req = 1'b1; if_addr = 32'h0000_0040;
        @(negedge clk);
        check("t1_stall_req", 32'(stall), 32'h03);
        tick();
        check("t1_bus_req", 32'(bus_req), 32'h1);
        check("t1_bus_addr", bus_addr, 32'h40);
        check("t1_bus_sel", 32'(bus_sel), 32'hF);
        tick(); tick();
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        check("t1_stall_ack", 32'(stall), 32'h00);
        tick();
        bus_ack = 1'b0; if_req = 1'b0;
        check("t1_if_valid", 32'(if_valid), 32'h1);
        check("t1_if_rdata", if_rdata, 32'h1234_5678);
        check("t1_bus_req_drop", 32'(bus_req), 32'h0);
        tick();
        check("t1_if_valid_pulse", 32'(if_valid), 32'h0);
        check("t1_if_rdata_hold", if_rdata, 32'h1234_5678);

        // Simultaneous requests: MEM first, IF after one idle cycle.
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h44;
        @(negedge clk);
        check("t2_stall_both", 32'(stall), 32'h1F);
        tick();
        check("t2_bus_addr_mem", bus_addr, 32'h200);
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("t2_stall_mem_ack", 32'(stall), 32'h03);
        tick();
        mem_req = 1'b0; bus_ack = 1'b0;
        check("t2_gap_bus_req", 32'(bus_req), 32'h0);
        check("t2_mem_valid", 32'(mem_valid), 32'h1);
        check("t2_mem_rdata", mem_rdata, 32'hCAFE_F00D);
        tick();
        check("t2_if_grant", 32'(bus_req), 32'h1);
        check("t2_if_addr", bus_addr, 32'h44);
        bus_ack = 1'b1; bus_rdata = 32'h0BAD_BEEF;
        tick();
        bus_ack = 1'b0; if_req = 1'b0;
        check("t2_if_rdata", if_rdata, 32'h0BAD_BEEF);
        tick();

        // Store: bus fields stay latched while the MEM inputs move.
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011;
        mem_addr = 32'h100; mem_wdata = 32'hAB;
        tick();
        check("t3_bus_we", 32'(bus_we), 32'h1);
        check("t3_bus_sel", 32'(bus_sel), 32'h3);
        check("t3_bus_wdata", bus_wdata, 32'hAB);
        mem_addr = 32'hDEAD_0000; mem_wdata = 32'hFFFF; mem_sel = 4'hF;
        tick();
        check("t3_addr_stable", bus_addr, 32'h100);
        check("t3_sel_stable", 32'(bus_sel), 32'h3);
        tick();
        check("t3_wdata_stable", bus_wdata, 32'hAB);
        bus_ack = 1'b1; bus_rdata = 32'h0;
        tick();
        bus_ack = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        check("t3_mem_valid", 32'(mem_valid), 32'h1);
        check("t3_bus_we_drop", 32'(bus_we), 32'h0);
        tick();

        // Fetch never acked: abort after TIMEOUT busy cycles.
        if_req = 1'b1; if_addr = 32'h80;
        tick();
        if_req = 1'b0;
        for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
            check("t4_no_err_early", 32'(bus_err), 32'h0);
            tick();
        end
        check("t4_req_last_cycle", 32'(bus_req), 32'h1);
        tick();
        check("t4_bus_err", 32'(bus_err), 32'h1);
        check("t4_bus_req_low", 32'(bus_req), 32'h0);
        check("t4_no_if_valid", 32'(if_valid), 32'h0);
        check("t4_rdata_kept", if_rdata, 32'h0BAD_BEEF);
        tick();
        check("t4_err_pulse", 32'(bus_err), 32'h0);

        // Flush during a fetch: transfer drains and its data is discarded.
        if_req = 1'b1; if_addr = 32'hC0;
        tick();
        flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        check("t5_stall_flush", 32'(stall), 32'h00);
        tick();
        flush = 1'b0;
        check("t5_drain_req", 32'(bus_req), 32'h1);
        check("t5_drain_addr", bus_addr, 32'hC0);
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        tick();
        bus_ack = 1'b0;
        check("t5_no_if_valid", 32'(if_valid), 32'h0);
        check("t5_rdata_kept", if_rdata, 32'h0BAD_BEEF);
        check("t5_bus_idle", 32'(bus_req), 32'h0);
        tick();

        // Stall priorities with no bus activity.
        stallreq_ex = 1'b1; stallreq_id = 1'b1;
        @(negedge clk);
        check("t6_stall_ex_id", 32'(stall), 32'h0F);
        tick();
        stallreq_ex = 1'b0;
        @(negedge clk);
        check("t6_stall_id", 32'(stall), 32'h07);
        tick();
        stallreq_id = 1'b0; stallreq_ex = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("t6_stall_flush", 32'(stall), 32'h00);
        tick();
        stallreq_ex = 1'b0; flush = 1'b0;
        tick();

        // Reset asserted in the middle of a data transfer.
        mem_req = 1'b1; mem_addr = 32'h300; mem_sel = 4'hF;
        tick();
        check("t7_busy", 32'(bus_req), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("t7_rst_bus_req", 32'(bus_req), 32'h0);
        check("t7_rst_bus_addr", bus_addr, 32'h0);
        check("t7_rst_stall", 32'(stall), 32'h0);
        check("t7_rst_mem_valid", 32'(mem_valid), 32'h0);
        check("t7_rst_mem_rdata", mem_rdata, 32'h0);
        mem_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("t7_post_rst_valid", 32'(mem_valid), 32'h0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
